sensor_scanner: RTL

SENSOR_SCANNER -- requirements
Module: sensor_scanner

---
 rtl/chess_pkg.sv | 18 +
 rtl/square_debouncer.sv | 53 +++++
 rtl/sensor_scanner.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/chess_pkg.sv
// Shared board geometry, reset occupancy and scanner FSM state encoding.
package chess_pkg;

    localparam int BOARD_ROWS    = 8;
    localparam int BOARD_COLS    = 8;
    localparam int BOARD_SQUARES = 64;

    // Standard starting position: ranks 1,2,7,8 occupied.
    localparam logic [63:0] INIT_OCCUPANCY = 64'hFFFF_0000_0000_FFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_UPDATE
    } scan_state_e;

endpackage

// File: rtl/square_debouncer.sv
// One board square: counts consecutive frames whose raw reading disagrees
// with the debounced state and flips the state after DEBOUNCE_SCANS of them.
module square_debouncer
    import chess_pkg::*;
#(
    parameter int   DEBOUNCE_SCANS = 3,
    parameter logic INIT_STATE     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic update_i,
    input  logic raw_i,
    output logic state_o,
    output logic flip_o
);

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_SCANS - 1);

    logic [3:0] cnt_q, cnt_d;
    logic       state_q, state_d;

    // Per-frame debounce decision; a reading that agrees again clears the count.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        flip_o  = 1'b0;
        if (update_i) begin
            if (raw_i == state_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                state_d = raw_i;
                cnt_d   = '0;
                flip_o  = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Counter and debounced bit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            state_q <= INIT_STATE;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/sensor_scanner.sv
// Hall-sensor chessboard scanner: drives one row at a time, lets it settle,
// samples the synchronised columns, then debounces the whole frame at once.
module sensor_scanner
    import chess_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 100,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     scan_en,
    input  logic [BOARD_COLS-1:0]    col_in,
    output logic [BOARD_ROWS-1:0]    row_drv,
    output logic [BOARD_SQUARES-1:0] sensor_state,
    output logic                     frame_done,
    output logic                     state_changed,
    output logic                     scan_busy
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    scan_state_e               state_q, state_d;
    logic [2:0]                r_q, r_d;
    logic [15:0]               cnt_q, cnt_d;
    logic [BOARD_COLS-1:0]     col_s1_q, col_s2_q;
    logic [BOARD_SQUARES-1:0]  raw_q;
    logic [BOARD_SQUARES-1:0]  flip;
    logic                      sample, update;
    logic                      frame_done_q, state_changed_q;

    // Two-flop synchroniser for the asynchronous column readback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1_q <= '0;
            col_s2_q <= '0;
        end else begin
            col_s1_q <= col_in;
            col_s2_q <= col_s1_q;
        end
    end

    // Scan sequencing: settle each row, sample it, debounce after row 7.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        row_drv = '0;
        sample  = 1'b0;
        update  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (scan_en) begin
                    state_d = S_DRIVE;
                    r_d     = '0;
                    cnt_d   = '0;
                end
            end
            S_DRIVE: begin
                row_drv = 8'd1 << r_q;
                if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
                else                      cnt_d   = cnt_q + 16'd1;
            end
            S_SAMPLE: begin
                row_drv = 8'd1 << r_q;
                sample  = 1'b1;
                if (r_q != 3'd7) begin
                    state_d = S_DRIVE;
                    r_d     = r_q + 3'd1;
                    cnt_d   = '0;
                end else begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                update = 1'b1;
                // A dropped scan_en only takes effect here, never mid-frame.
                if (scan_en) begin
                    state_d = S_DRIVE;
                    r_d     = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM, row index and settle counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
        end
    end

    // Raw frame capture of the current row; held until the next frame overwrites it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      raw_q <= INIT_OCCUPANCY;
        else if (sample) raw_q[{r_q, 3'b000} +: BOARD_COLS] <= col_s2_q;
    end

    // Frame pulses register on the same edge as the debounced state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_q    <= 1'b0;
            state_changed_q <= 1'b0;
        end else begin
            frame_done_q    <= update;
            state_changed_q <= update & (|flip);
        end
    end

    genvar g;
    generate
        for (g = 0; g < BOARD_SQUARES; g++) begin : g_sq
            square_debouncer #(
                .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
                .INIT_STATE     (INIT_OCCUPANCY[g])
            ) u_sq (
                .clk      (clk),
                .rst_n    (rst_n),
                .update_i (update),
                .raw_i    (raw_q[g]),
                .state_o  (sensor_state[g]),
                .flip_o   (flip[g])
            );
        end
    endgenerate

    assign frame_done    = frame_done_q;
    assign state_changed = state_changed_q;
    assign scan_busy     = (state_q != S_IDLE);

endmodule
